// File: rtl/writeback_pkg.sv
// Shared opcode/funct3 constants and the writeback-register record used by
// the final pipeline stage and its register file.
package writeback_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RA_W = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] am;
    } wb_entry_t;

    function automatic logic is_link(input logic [6:0] opcode);
        return (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/writeback_regfile_2r1w.sv
// 32x32 integer register file: two combinational read ports with write-through
// bypass, one write port, x0 hardwired to zero.
import writeback_pkg::*;

module regfile_2r1w #(
    parameter logic [31:0] REG_INIT = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr1,
    input  logic [RA_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [0:NREG-1];
    logic            wr_live;

    assign wr_live = we && (waddr != '0);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    mem[gi] <= '0;
                end
            end else begin : g_live
                always_ff @(posedge clk) begin
                    if (rst) begin
                        mem[gi] <= REG_INIT;
                    end else if (wr_live && (waddr == RA_W'(gi))) begin
                        mem[gi] <= wdata;
                    end
                end
            end
        end
    endgenerate

    // A register being written this cycle is visible on the read port at once,
    // so decode never sees a stale value for the instruction retiring now.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wr_live && (waddr == raddr1)) ? wdata : mem[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = (wr_live && (waddr == raddr2)) ? wdata : mem[raddr2];
        end
    end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: holds one instruction, builds its architectural result,
// commits it into the register file and counts retired instructions.
import writeback_pkg::*;

module writeback #(
    parameter int          CNT_W    = 64,
    parameter logic [31:0] REG_INIT = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IR,
    input  logic [31:0]      RD,
    input  logic [31:0]      A,
    input  logic [31:0]      PC,
    input  logic [4:0]       AM,
    input  logic             v_in,
    input  logic             stall,
    output logic             r_out,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] instret
);

    wb_entry_t        wb_reg;
    wb_entry_t        wb_next;
    logic             wb_valid_reg;
    logic             wb_valid_next;
    logic             r_out_reg;
    logic [CNT_W-1:0] instret_reg;

    logic             accept;
    logic             commit;
    logic [31:0]      result;
    logic             has_dest;

    assign accept   = v_in & r_out_reg & ~stall;
    assign commit   = wb_valid_reg & ~stall;
    assign has_dest = wb_reg.am != '0;

    always_comb begin
        wb_next       = wb_reg;
        wb_valid_next = wb_valid_reg;
        if (accept) begin
            wb_next.ir    = IR;
            wb_next.rd    = RD;
            wb_next.a     = A;
            wb_next.pc    = PC;
            wb_next.am    = AM;
            wb_valid_next = 1'b1;
        end else if (commit) begin
            wb_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg       <= '0;
            wb_valid_reg <= 1'b0;
            r_out_reg    <= 1'b1;
            instret_reg  <= '0;
        end else begin
            wb_reg       <= wb_next;
            wb_valid_reg <= wb_valid_next;
            r_out_reg    <= ~stall;
            if (commit) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    // Upper load-data bits are undefined upstream, so every width is rebuilt
    // from the low bits only.
    always_comb begin
        result = wb_reg.a;
        if (wb_reg.ir[6:0] == OP_LOAD) begin
            case (wb_reg.ir[14:12])
                F3_LB:   result = {{24{wb_reg.rd[7]}}, wb_reg.rd[7:0]};
                F3_LH:   result = {{16{wb_reg.rd[15]}}, wb_reg.rd[15:0]};
                F3_LW:   result = wb_reg.rd;
                F3_LBU:  result = {24'h0, wb_reg.rd[7:0]};
                F3_LHU:  result = {16'h0, wb_reg.rd[15:0]};
                default: result = '0;
            endcase
        end else if (is_link(wb_reg.ir[6:0])) begin
            result = wb_reg.pc + 32'd4;
        end
    end

    regfile_2r1w #(
        .REG_INIT (REG_INIT)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (commit & has_dest),
        .waddr  (wb_reg.am),
        .wdata  (result),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign fwd_valid = wb_valid_reg & has_dest;
    assign fwd_rd    = fwd_valid ? wb_reg.am : 5'd0;
    assign fwd_data  = result;
    assign r_out     = r_out_reg;
    assign instret   = instret_reg;

endmodule

// File: tb/tb_writeback.sv
// Directed-vector bench for the writeback stage: loads, links, x0, stall,
// back-to-back issue and reset with a pending instruction.
module tb_writeback;

    localparam logic [31:0] RINIT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR, RD, A, PC;
    logic [4:0]  AM;
    logic        v_in, stall;
    logic        r_out;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        fwd_valid;
    logic [63:0] instret;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_instret = 64'd0;

    always #5 clk = ~clk;

    writeback #(.CNT_W(64), .REG_INIT(RINIT)) dut (
        .clk(clk), .rst(rst), .IR(IR), .RD(RD), .A(A), .PC(PC), .AM(AM),
        .v_in(v_in), .stall(stall), .r_out(r_out),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
        .instret(instret)
    );

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'h0, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accept edge.
    task automatic issue(input logic [31:0] ir, input logic [31:0] rd,
                         input logic [31:0] a, input logic [31:0] pc,
                         input logic [4:0] am);
        IR = ir; RD = rd; A = a; PC = pc; AM = am; v_in = 1'b1;
        step();
        v_in = 1'b0;
    endtask

    // Issue, let it commit, then read back the destination.
    task automatic run_one(input string name, input logic [31:0] ir,
                           input logic [31:0] rd, input logic [31:0] a,
                           input logic [31:0] pc, input logic [4:0] am,
                           input logic [31:0] expv);
        issue(ir, rd, a, pc, am);
        step();
        exp_instret = exp_instret + 64'd1;
        rs1_addr = am;
        #1;
        vectors++;
        if (rs1_data !== expv) begin
            miscompares++;
            $display("FAIL %s: x%0d got %h expected %h", name, am, rs1_data, expv);
        end else
            $display("ok   %s: x%0d = %h", name, am, rs1_data);
        vectors++;
        if (instret !== exp_instret) begin
            miscompares++;
            $display("FAIL %s_instret: got %0d expected %0d", name, instret, exp_instret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        vectors++;
        if ({r_out, fwd_valid, fwd_rd} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: r_out=%b fwd_valid=%b fwd_rd=%0d expected 1 0 0", r_out, fwd_valid, fwd_rd);
        end
        vectors++;
        if (instret !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
        vectors++;
        if (rs1_data !== RINIT || rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: x5=%h x0=%h expected %h 0", rs1_data, rs2_data, RINIT);
        end
        $display("ok   reset applied");
    endtask

    task automatic test_loads();
        // Forwarding view of the LB while it sits in the WB register.
        issue(mk_ir(3'b000, 7'b0000011), 32'h0000_00F0, 32'h0, 32'h0, 5'd5);
        vectors++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'hFFFF_FFF0}) begin
            miscompares++;
            $display("FAIL lb_fwd: v=%b rd=%0d data=%h expected 1 5 fffffff0", fwd_valid, fwd_rd, fwd_data);
        end
        step();
        exp_instret = exp_instret + 64'd1;
        rs1_addr = 5'd5;
        #1;
        vectors++;
        if (rs1_data !== 32'hFFFF_FFF0 || instret !== exp_instret) begin
            miscompares++;
            $display("FAIL lb: x5=%h instret=%0d expected fffffff0 %0d", rs1_data, instret, exp_instret);
        end else
            $display("ok   lb: x5 = %h", rs1_data);
        run_one("lhu", mk_ir(3'b101, 7'b0000011), 32'h0000_BEEF, 32'h0, 32'h0, 5'd6, 32'h0000_BEEF);
        run_one("lh",  mk_ir(3'b001, 7'b0000011), 32'h0000_BEEF, 32'h0, 32'h0, 5'd6, 32'hFFFF_BEEF);
        run_one("lw",  mk_ir(3'b010, 7'b0000011), 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd8, 32'hDEAD_BEEF);
        run_one("lbu", mk_ir(3'b100, 7'b0000011), 32'h1234_5680, 32'h0, 32'h0, 5'd8, 32'h0000_0080);
        run_one("lbad", mk_ir(3'b011, 7'b0000011), 32'hFFFF_FFFF, 32'h7, 32'h0, 5'd8, 32'h0000_0000);
    endtask

    task automatic test_links();
        run_one("jal",  mk_ir(3'b000, 7'b1101111), 32'h0, 32'h9999, 32'h0000_0100, 5'd1, 32'h0000_0104);
        run_one("jalr", mk_ir(3'b000, 7'b1100111), 32'h0, 32'h9999, 32'hFFFF_FFFC, 5'd2, 32'h0000_0000);
    endtask

    task automatic test_x0();
        issue(mk_ir(3'b000, 7'b0110011), 32'h0, 32'h1234_5678, 32'h0, 5'd0);
        vectors++;
        if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL add_x0_fwd: v=%b rd=%0d expected 0 0", fwd_valid, fwd_rd);
        end
        issue(mk_ir(3'b010, 7'b0100011), 32'h0, 32'h0000_0040, 32'h0, 5'd0);
        vectors++;
        if (fwd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_fwd: v=%b expected 0", fwd_valid);
        end
        step();
        exp_instret = exp_instret + 64'd2;
        rs1_addr = 5'd0;
        #1;
        vectors++;
        if (rs1_data !== 32'h0 || instret !== exp_instret) begin
            miscompares++;
            $display("FAIL x0: x0=%h instret=%0d expected 0 %0d", rs1_data, instret, exp_instret);
        end else
            $display("ok   add/sw to x0: instret = %0d", instret);
    endtask

    task automatic test_stall();
        issue(mk_ir(3'b000, 7'b0010011), 32'h0, 32'h0000_CAFE, 32'h0, 5'd7);
        stall = 1'b1;
        rs1_addr = 5'd7;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (r_out !== 1'b0 || fwd_rd !== 5'd7 || fwd_valid !== 1'b1 || fwd_data !== 32'h0000_CAFE) begin
                miscompares++;
                $display("FAIL stall_hold%0d: r_out=%b fwd_rd=%0d fwd_v=%b data=%h expected 0 7 1 0000cafe", c, r_out, fwd_rd, fwd_valid, fwd_data);
            end
            vectors++;
            if (rs1_data !== RINIT || instret !== exp_instret) begin
                miscompares++;
                $display("FAIL stall_nowrite%0d: x7=%h instret=%0d expected %h %0d", c, rs1_data, instret, RINIT, exp_instret);
            end
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (rs1_data !== 32'h0000_CAFE) begin
            miscompares++;
            $display("FAIL bypass: x7 read %h expected 0000cafe", rs1_data);
        end else
            $display("ok   bypass during commit: x7 = %h", rs1_data);
        step();
        exp_instret = exp_instret + 64'd1;
        vectors++;
        if (rs1_data !== 32'h0000_CAFE || instret !== exp_instret || fwd_valid !== 1'b0 || r_out !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: x7=%h instret=%0d fwd_v=%b r_out=%b expected 0000cafe %0d 0 1", rs1_data, instret, fwd_valid, r_out, exp_instret);
        end
    endtask

    task automatic test_back_to_back();
        IR = mk_ir(3'b000, 7'b0110011); A = 32'h11; AM = 5'd10; v_in = 1'b1;
        step();
        A = 32'h22; AM = 5'd11;
        step();
        v_in = 1'b0;
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        vectors++;
        if (rs1_data !== 32'h11 || fwd_rd !== 5'd11 || fwd_data !== 32'h22) begin
            miscompares++;
            $display("FAIL b2b_first: x10=%h fwd_rd=%0d fwd_data=%h expected 11 11 22", rs1_data, fwd_rd, fwd_data);
        end
        step();
        exp_instret = exp_instret + 64'd2;
        vectors++;
        if (rs2_data !== 32'h22 || instret !== exp_instret) begin
            miscompares++;
            $display("FAIL b2b_second: x11=%h instret=%0d expected 22 %0d", rs2_data, instret, exp_instret);
        end else
            $display("ok   back-to-back: x10=%h x11=%h", rs1_data, rs2_data);
    endtask

    task automatic test_reset_pending();
        issue(mk_ir(3'b000, 7'b0010011), 32'h0, 32'h55, 32'h0, 5'd9);
        rst = 1'b1; stall = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        vectors++;
        if (rs1_data !== RINIT || rs2_data !== RINIT) begin
            miscompares++;
            $display("FAIL rst_pending_regs: x9=%h x5=%h expected %h", rs1_data, rs2_data, RINIT);
        end
        vectors++;
        if (fwd_valid !== 1'b0 || r_out !== 1'b1 || instret !== 64'd0) begin
            miscompares++;
            $display("FAIL rst_pending_ctrl: fwd_v=%b r_out=%b instret=%0d expected 0 1 0", fwd_valid, r_out, instret);
        end
        step();
        vectors++;
        if (rs1_data !== RINIT || instret !== 64'd0) begin
            miscompares++;
            $display("FAIL rst_discard: x9=%h instret=%0d expected %h 0", rs1_data, instret, RINIT);
        end else
            $display("ok   reset with pending instruction: x9 = %h", rs1_data);
    endtask

    initial begin
        rst = 1'b1; IR = '0; RD = '0; A = '0; PC = '0; AM = '0;
        v_in = 1'b0; stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
        test_reset();
        test_loads();
        test_links();
        test_x0();
        test_stall();
        test_back_to_back();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
